// File: rtl/dram_pkg.sv
// Shared DDR3 init types: command bundle, command constants and sequencer states.
package dram_pkg;

    typedef struct packed {
        logic cs_n;
        logic ras_n;
        logic cas_n;
        logic we_n;
    } dram_cmd_t;

    localparam dram_cmd_t CMD_NOP  = dram_cmd_t'(4'b0111);
    localparam dram_cmd_t CMD_DES  = dram_cmd_t'(4'b1111);
    localparam dram_cmd_t CMD_MRS  = dram_cmd_t'(4'b0000);
    localparam dram_cmd_t CMD_ZQCL = dram_cmd_t'(4'b0110);

    // ZQCL is distinguished from ZQCS by A10 high
    localparam logic [15:0] ZQCL_ADDR = 16'h0400;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_RST_WAIT = 4'd1,
        ST_CKE_WAIT = 4'd2,
        ST_XPR_WAIT = 4'd3,
        ST_MRS2     = 4'd4,
        ST_MRS3     = 4'd5,
        ST_MRS1     = 4'd6,
        ST_MRS0     = 4'd7,
        ST_ZQCL     = 4'd8,
        ST_DONE     = 4'd9
    } init_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dram_wait_cnt.sv
// Loadable down-counter that parks at zero; zero flags the last cycle of a timed state.
module dram_wait_cnt #(
    parameter int W = 17
) (
    input  logic         dclk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge dclk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/dram_init_seq.sv
// DDR3 power-up sequencer: reset hold, CKE wait, tXPR, MR2/3/1/0, ZQCL, then init_done.
module dram_init_seq
    import dram_pkg::*;
#(
    parameter int          T_RESET_CYC  = 40000,
    parameter int          T_CKE_CYC    = 100000,
    parameter int          T_XPR_CYC    = 54,
    parameter int          T_MRD_CYC    = 4,
    parameter int          T_MOD_CYC    = 12,
    parameter int          T_ZQINIT_CYC = 512,
    parameter logic [15:0] MR0_VAL      = 16'h1D70,
    parameter logic [15:0] MR1_VAL      = 16'h0006,
    parameter logic [15:0] MR2_VAL      = 16'h0018,
    parameter logic [15:0] MR3_VAL      = 16'h0000
) (
    input  logic        dclk,
    input  logic        reset,
    input  logic        start,
    output logic        reset_n,
    output logic        cke,
    output logic        cs_n,
    output logic        ras_n,
    output logic        cas_n,
    output logic        we_n,
    output logic [2:0]  ba,
    output logic [15:0] addr,
    output logic        odt,
    output logic        init_done,
    output logic [3:0]  state_dbg
);

    localparam int T_MAX = max_int(max_int(max_int(T_RESET_CYC, T_CKE_CYC),
                                           max_int(T_XPR_CYC, T_MRD_CYC)),
                                   max_int(T_MOD_CYC, T_ZQINIT_CYC));
    localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    if (T_RESET_CYC < 1 || T_CKE_CYC < 1 || T_XPR_CYC < 1 || T_ZQINIT_CYC < 1 ||
        T_MRD_CYC < 4 || T_MOD_CYC < 12) begin : g_bad_timing
        $error("dram_init_seq: illegal timing parameters");
    end

    init_state_t      state;
    init_state_t      state_next;
    logic             first_cyc;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_zero;

    logic             reset_n_d;
    logic             cke_d;
    dram_cmd_t        cmd_d;
    dram_cmd_t        cmd_q;
    logic [2:0]       ba_d;
    logic [15:0]      addr_d;
    logic             done_d;

    dram_wait_cnt #(.W(CNT_W)) u_wait_cnt (
        .dclk     (dclk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .zero     (cnt_zero)
    );

    // State plus the registered pin image, so every output is one flop from the pad
    always_ff @(posedge dclk) begin
        if (reset) begin
            state     <= ST_IDLE;
            first_cyc <= 1'b0;
            reset_n   <= 1'b0;
            cke       <= 1'b0;
            cmd_q     <= CMD_DES;
            ba        <= 3'd0;
            addr      <= 16'd0;
            init_done <= 1'b0;
        end else begin
            state     <= state_next;
            first_cyc <= cnt_load;
            reset_n   <= reset_n_d;
            cke       <= cke_d;
            cmd_q     <= cmd_d;
            ba        <= ba_d;
            addr      <= addr_d;
            init_done <= done_d;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (start)    state_next = ST_RST_WAIT;
            ST_RST_WAIT: if (cnt_zero) state_next = ST_CKE_WAIT;
            ST_CKE_WAIT: if (cnt_zero) state_next = ST_XPR_WAIT;
            ST_XPR_WAIT: if (cnt_zero) state_next = ST_MRS2;
            ST_MRS2:     if (cnt_zero) state_next = ST_MRS3;
            ST_MRS3:     if (cnt_zero) state_next = ST_MRS1;
            ST_MRS1:     if (cnt_zero) state_next = ST_MRS0;
            ST_MRS0:     if (cnt_zero) state_next = ST_ZQCL;
            ST_ZQCL:     if (cnt_zero) state_next = ST_DONE;
            ST_DONE:     state_next = ST_DONE;
            default:     state_next = ST_IDLE;
        endcase

        // Counter is reloaded with the duration of the state being entered
        cnt_load     = (state_next != state);
        cnt_load_val = '0;
        case (state_next)
            ST_RST_WAIT: cnt_load_val = CNT_W'(T_RESET_CYC - 1);
            ST_CKE_WAIT: cnt_load_val = CNT_W'(T_CKE_CYC - 1);
            ST_XPR_WAIT: cnt_load_val = CNT_W'(T_XPR_CYC - 1);
            ST_MRS2,
            ST_MRS3,
            ST_MRS1:     cnt_load_val = CNT_W'(T_MRD_CYC - 1);
            ST_MRS0:     cnt_load_val = CNT_W'(T_MOD_CYC - 1);
            ST_ZQCL:     cnt_load_val = CNT_W'(T_ZQINIT_CYC - 1);
            default:     cnt_load_val = '0;
        endcase
    end

    always_comb begin
        reset_n_d = 1'b1;
        cke_d     = 1'b1;
        cmd_d     = CMD_NOP;
        ba_d      = 3'd0;
        addr_d    = 16'd0;
        done_d    = 1'b0;
        case (state)
            ST_IDLE,
            ST_RST_WAIT: begin
                reset_n_d = 1'b0;
                cke_d     = 1'b0;
                cmd_d     = CMD_DES;
            end
            ST_CKE_WAIT: begin
                cke_d = 1'b0;
                cmd_d = CMD_DES;
            end
            ST_MRS2: if (first_cyc) begin
                cmd_d  = CMD_MRS;
                ba_d   = 3'd2;
                addr_d = MR2_VAL;
            end
            ST_MRS3: if (first_cyc) begin
                cmd_d  = CMD_MRS;
                ba_d   = 3'd3;
                addr_d = MR3_VAL;
            end
            ST_MRS1: if (first_cyc) begin
                cmd_d  = CMD_MRS;
                ba_d   = 3'd1;
                addr_d = MR1_VAL;
            end
            ST_MRS0: if (first_cyc) begin
                cmd_d  = CMD_MRS;
                ba_d   = 3'd0;
                addr_d = MR0_VAL;
            end
            ST_ZQCL: if (first_cyc) begin
                cmd_d  = CMD_ZQCL;
                addr_d = ZQCL_ADDR;
            end
            ST_DONE: done_d = 1'b1;
            default: ;
        endcase
    end

    assign cs_n      = cmd_q.cs_n;
    assign ras_n     = cmd_q.ras_n;
    assign cas_n     = cmd_q.cas_n;
    assign we_n      = cmd_q.we_n;
    assign odt       = 1'b0;
    assign state_dbg = state;

endmodule

// File: tb/tb_dram_init_seq.sv
// Scoreboard bench for dram_init_seq with short timings and randomized start/reset points.
module tb_dram_init_seq;
    import dram_pkg::*;

    localparam int TR = 10, TC = 20, TX = 5, TM = 4, TMOD = 12, TZ = 16;
    localparam logic [15:0] MR0 = 16'h1D70, MR1 = 16'h0006, MR2 = 16'h0018, MR3 = 16'h0000;

    logic        dclk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        reset_n, cke, cs_n, ras_n, cas_n, we_n, odt, init_done;
    logic [2:0]  ba;
    logic [15:0] addr;
    logic [3:0]  state_dbg;

    dram_init_seq #(
        .T_RESET_CYC(TR), .T_CKE_CYC(TC), .T_XPR_CYC(TX), .T_MRD_CYC(TM),
        .T_MOD_CYC(TMOD), .T_ZQINIT_CYC(TZ),
        .MR0_VAL(MR0), .MR1_VAL(MR1), .MR2_VAL(MR2), .MR3_VAL(MR3)
    ) dut (
        .dclk(dclk), .reset(reset), .start(start),
        .reset_n(reset_n), .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n),
        .we_n(we_n), .ba(ba), .addr(addr), .odt(odt), .init_done(init_done),
        .state_dbg(state_dbg)
    );

    always #5 dclk = ~dclk;

    int edge_cnt = 0;
    always @(posedge dclk) edge_cnt++;

    int checks = 0;
    int errors = 0;

    typedef enum int {EV_RSTN, EV_CKE, EV_CMD, EV_DONE} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        int          t;
        logic [3:0]  cmd;
        logic [2:0]  ba;
        logic [15:0] addr;
    } ev_t;
    ev_t exp_q[$];

    task automatic push_ev(input ev_kind_t k, input int t, input logic [3:0] c,
                           input logic [2:0] b, input logic [15:0] a);
        ev_t e;
        e.kind = k; e.t = t; e.cmd = c; e.ba = b; e.addr = a;
        exp_q.push_back(e);
    endtask

    // Reference timeline: each event is the previous one plus that phase's duration
    task automatic model_sequence(input int base);
        int t;
        t = base + 1 + TR;  push_ev(EV_RSTN, t, 4'b0000, 3'd0, 16'h0000);
        t = t + TC;         push_ev(EV_CKE,  t, 4'b0000, 3'd0, 16'h0000);
        t = t + TX;         push_ev(EV_CMD,  t, 4'b0000, 3'd2, MR2);
        t = t + TM;         push_ev(EV_CMD,  t, 4'b0000, 3'd3, MR3);
        t = t + TM;         push_ev(EV_CMD,  t, 4'b0000, 3'd1, MR1);
        t = t + TM;         push_ev(EV_CMD,  t, 4'b0000, 3'd0, MR0);
        t = t + TMOD;       push_ev(EV_CMD,  t, 4'b0110, 3'd0, 16'h0400);
        t = t + TZ;         push_ev(EV_DONE, t, 4'b0000, 3'd0, 16'h0000);
    endtask

    task automatic handle_ev(input ev_kind_t k, input logic [3:0] c,
                             input logic [2:0] b, input logic [15:0] a);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_event: kind=%0d at edge %0d cmd=%b ba=%0d addr=%h, none required",
                     k, edge_cnt, c, b, a);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.t != edge_cnt ||
                (k == EV_CMD && (c !== e.cmd || b !== e.ba || a !== e.addr))) begin
                errors++;
                $display("[TB] FAIL event: got kind=%0d edge=%0d cmd=%b ba=%0d addr=%h, required kind=%0d edge=%0d cmd=%b ba=%0d addr=%h",
                         k, edge_cnt, c, b, a, e.kind, e.t, e.cmd, e.ba, e.addr);
            end
        end
    endtask

    logic mon_on = 1'b0;
    logic p_rstn = 1'b0, p_cke = 1'b0, p_done = 1'b0, p_reset = 1'b1;

    // Monitor: protocol rules every cycle, plus event extraction for the scoreboard
    always @(negedge dclk) begin
        if (mon_on) begin
            checks++;
            if (odt !== 1'b0) begin
                errors++;
                $display("[TB] FAIL odt_low: odt=%b required 0 at edge %0d", odt, edge_cnt);
            end
            checks++;
            if (cke !== 1'b1 && cs_n !== 1'b1) begin
                errors++;
                $display("[TB] FAIL deselect_while_cke_low: cs_n=%b required 1 at edge %0d", cs_n, edge_cnt);
            end
            checks++;
            if (p_done === 1'b1 && init_done !== 1'b1 && p_reset !== 1'b1) begin
                errors++;
                $display("[TB] FAIL done_sticky: init_done=%b required 1 at edge %0d", init_done, edge_cnt);
            end
            if (cke === 1'b1 && {cs_n, ras_n, cas_n, we_n} === 4'b0111) begin
                checks++;
                if (ba !== 3'd0 || addr !== 16'd0) begin
                    errors++;
                    $display("[TB] FAIL nop_fields: ba=%0d addr=%h required 0/0000 at edge %0d", ba, addr, edge_cnt);
                end
            end
            if (reset_n === 1'b1 && p_rstn !== 1'b1) handle_ev(EV_RSTN, 4'b0000, 3'd0, 16'h0000);
            if (cke === 1'b1 && p_cke !== 1'b1)      handle_ev(EV_CKE, 4'b0000, 3'd0, 16'h0000);
            if (cs_n === 1'b0 && {cs_n, ras_n, cas_n, we_n} !== 4'b0111)
                handle_ev(EV_CMD, {cs_n, ras_n, cas_n, we_n}, ba, addr);
            if (init_done === 1'b1 && p_done !== 1'b1) handle_ev(EV_DONE, 4'b0000, 3'd0, 16'h0000);
            p_rstn  = reset_n;
            p_cke   = cke;
            p_done  = init_done;
            p_reset = reset;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge dclk);
        #1;
    endtask

    // Raise start so the next edge samples it, and queue the required timeline
    task automatic applyStimulus(output int base);
        base  = edge_cnt + 1;
        start = 1'b1;
        model_sequence(base);
    endtask

    task automatic checkOutput(input string name);
        logic [30:0] act, req;
        @(negedge dclk);
        act = {reset_n, cke, cs_n, ras_n, cas_n, we_n, ba, addr, odt, init_done, state_dbg};
        req = {1'b0, 1'b0, 4'b1111, 3'd0, 16'd0, 1'b0, 1'b0, 4'(ST_IDLE)};
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: outputs=%h required %h at edge %0d", name, act, req, edge_cnt);
        end
    endtask

    task automatic do_reset(input string name);
        int e;
        e     = edge_cnt + 1;
        reset = 1'b1;
        start = 1'b0;
        for (int i = exp_q.size() - 1; i >= 0; i--)
            if (exp_q[i].t >= e) exp_q.delete(i);
        tick(1);
        reset = 1'b0;
        checkOutput(name);
        tick(1);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s: %0d events outstanding, required 0 (next at edge %0d)",
                     name, exp_q.size(), exp_q[0].t);
            exp_q.delete();
        end
    endtask

    initial begin
        int base;
        int r;
        tick(2);
        reset  = 1'b0;
        mon_on = 1'b1;
        checkOutput("reset_state");

        $display("[TB] idle hold with start low");
        for (int i = 0; i < 100; i++) checkOutput("idle_hold");

        $display("[TB] full sequence");
        tick($urandom_range(1, 6));
        applyStimulus(base);
        wait_drain("seq_full", 200);
        tick(10);

        $display("[TB] reset during MRS1");
        do_reset("reset_before_seq2");
        tick($urandom_range(1, 6));
        applyStimulus(base);
        r = $urandom_range(0, 3);
        tick(44 + r);
        do_reset("reset_in_mrs1");
        wait_drain("seq_pre_reset", 1);
        tick($urandom_range(1, 6));
        applyStimulus(base);
        tick(1);
        start = 1'b0;
        wait_drain("seq_after_reset", 200);
        tick(10);

        $display("[TB] start toggled during CKE_WAIT");
        do_reset("reset_before_seq3");
        tick($urandom_range(1, 6));
        applyStimulus(base);
        tick($urandom_range(12, 20));
        start = 1'b0;
        tick($urandom_range(1, 5));
        start = 1'b1;
        tick($urandom_range(1, 3));
        start = 1'b0;
        wait_drain("seq_start_toggle", 200);
        tick(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dram_init_seq.md
Name: dram_init_seq

Overview:
- DDR3 power-up and initialization sequencer in the dclk domain.
- Sits directly upstream of the DRAM IO/PHY block and drives its per-dclk command/control inputs: reset_n, cke, cs_n, ras_n, cas_n, we_n, ba, addr, odt.
- Runs the JEDEC sequence: reset hold, CKE-low wait, tXPR, MR2/MR3/MR1/MR0 loads, ZQCL, then asserts init_done.
- After init_done, the controller mux selects the command source; this block then only holds NOP.

Parameters:
T_RESET_CYC, 40000, dclk cycles reset_n held low after start (200 us at 200 MHz)
T_CKE_CYC, 100000, dclk cycles from reset_n rise to cke rise (500 us)
T_XPR_CYC, 54, dclk cycles from cke rise to first MRS
T_MRD_CYC, 4, dclk cycles between consecutive MRS commands
T_MOD_CYC, 12, dclk cycles from MR0 to ZQCL
T_ZQINIT_CYC, 512, dclk cycles from ZQCL to init_done
MR0_VAL, 16'h1D70, addr value for MR0 (ba=0)
MR1_VAL, 16'h0006, addr value for MR1 (ba=1)
MR2_VAL, 16'h0018, addr value for MR2 (ba=2)
MR3_VAL, 16'h0000, addr value for MR3 (ba=3)

Ports:
dclk  in  1  clock; all logic on the rising edge
reset  in  1  synchronous, active-high
start  in  1  level; begin the sequence (tie to PLL lock AND idelayctl ready)
reset_n  out  1  DRAM reset
cke  out  1  clock enable (drives both ranks)
cs_n  out  1  chip select
ras_n  out  1
cas_n  out  1
we_n  out  1
ba  out  3  bank address
addr  out  16  address / mode register value
odt  out  1  held 0 throughout
init_done  out  1  sticky high after the sequence completes
state_dbg  out  4  current state encoding

Behaviour:
- All outputs registered; no combinational paths from inputs to outputs.
- Reset values: reset_n=0, cke=0, cs_n=1, ras_n=1, cas_n=1, we_n=1, ba=0, addr=0, odt=0, init_done=0, state=IDLE.
- Command encodings:
  - NOP: cs_n=0, ras_n=1, cas_n=1, we_n=1.
  - MRS: cs_n=0, ras_n=0, cas_n=0, we_n=0.
  - ZQCL: cs_n=0, ras_n=1, cas_n=1, we_n=0, addr[10]=1, other addr bits 0.
  - Deselect (cs_n=1) is driven while cke=0.
- Each command is asserted for exactly 1 dclk cycle. All non-command cycles with cke=1 carry NOP with ba=0, addr=0.
- Wait counter: one down-counter, width $clog2 of the largest T_* parameter. It loads T-1 on state entry and leaves the state on the cycle it reads 0, so each timed state lasts exactly T cycles.
- States and transitions:
  - IDLE: reset_n=0. Go to RST_WAIT when start=1.
  - RST_WAIT: T_RESET_CYC cycles. On exit, reset_n=1.
  - CKE_WAIT: T_CKE_CYC cycles. On exit, cke=1.
  - XPR_WAIT: T_XPR_CYC cycles.
  - MRS2: MR2 issued on the first cycle; state lasts T_MRD_CYC.
  - MRS3: same, with MR3.
  - MRS1: same, with MR1.
  - MRS0: MR0 issued on the first cycle; state lasts T_MOD_CYC.
  - ZQCL: ZQCL issued on the first cycle; state lasts T_ZQINIT_CYC.
  - DONE: init_done=1; remains there until reset.
- Timing relative to edge k, where start is first sampled high in IDLE:
  - reset_n rises at output edge k+1+T_RESET_CYC.
  - Each later event is spaced by the preceding state's T value.
- start deasserted after leaving IDLE: ignored; the sequence completes.
- reset during any state: next cycle is IDLE with all reset values (reset_n=0, cke=0). The sequence restarts from the beginning on the next start.
- Parameter legality: every T_* must be ≥1, checked by elaboration assertion. T_MRD_CYC ≥4 and T_MOD_CYC ≥12 are DDR3 minimums, checked by the same assertion.

Decomposition:
- Shared package dram_pkg holds:
  - dram_cmd_t: packed struct {cs_n, ras_n, cas_n, we_n}.
  - Constants CMD_NOP, CMD_DES, CMD_MRS, CMD_ZQCL.
  - init_state_t enum, whose encodings feed state_dbg.
- One sub-module: dram_wait_cnt. Loadable down-counter with inputs load, load_val, dclk, reset; output zero.

Test Plan:
- Short-timing run: T_RESET=10, T_CKE=20, T_XPR=5, T_MRD=4, T_MOD=12, T_ZQINIT=16; start high at edge 0. Required events:
  - reset_n rise at edge 11.
  - cke rise at edge 31.
  - MR2 at edge 36, MR3 at 40, MR1 at 44, MR0 at 48.
  - ZQCL at 60.
  - init_done at 76.
- MRS content in the same run: ba/addr equal 2/MR2_VAL, 3/MR3_VAL, 1/MR1_VAL, 0/MR0_VAL. ZQCL cycle has addr=16'h0400. Each command lasts exactly 1 cycle, with NOP in between.
- Reset pulse during MRS1: the next cycle shows reset_n=0, cke=0, cs_n=1, init_done=0, state IDLE. Raising start again reproduces the full sequence timing from scenario 1.
- start held low for 100 cycles after reset: outputs stay at reset values and state_dbg stays IDLE.
- start toggled low during CKE_WAIT: the sequence timing is unchanged and init_done still rises at edge 76.
- Protocol checker, run throughout all scenarios: no command while cke=0 (only deselect), odt always 0, init_done never falls without reset.
